// File: rtl/jtag_driver.sv
// JTAG master: walks the TAP with fixed TMS sequences for reset, IR/DR scans and idle runs.
// Optional JTAG_DRV_TRST_EN prepends a 2-step trst pulse (tck held low) to the RESET command.
module jtag_driver #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 5,
  parameter int TCK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo,
  output logic              trst
);

  localparam int CW = $clog2(2 * TCK_DIV);
  localparam int RW = (LEN_W > 3) ? LEN_W : 3;
  localparam logic [CW-1:0] HI_START = CW'(TCK_DIV - 1);
  localparam logic [CW-1:0] STEP_END = CW'(2 * TCK_DIV - 1);

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;
  localparam logic [1:0] OP_IDLE  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_TRST, ST_TMS_SEQ, ST_SHIFT, ST_EXIT, ST_DONE
  } state_t;

  state_t            state;
  logic [1:0]        op;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_c;
  logic [LEN_W-1:0]  idx;
  logic [RW-1:0]     rem;
  logic [CW-1:0]     cnt;
  logic [4:0]        tms_sr;
  logic [DATA_W-1:0] dat_sr;
  logic [DATA_W-1:0] cap;

  always_comb begin
    len_c = cmd_len;
    if ({1'b0, cmd_len} >= (LEN_W + 1)'(DATA_W)) len_c = LEN_W'(DATA_W - 1);
  end

  // rem counts the steps still to run in the current state after the one in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      trst      <= 1'b1;
      op        <= OP_RESET;
      len       <= '0;
      idx       <= '0;
      rem       <= '0;
      cnt       <= '0;
      tms_sr    <= '0;
      dat_sr    <= '0;
      cap       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            op        <= cmd_op;
            len       <= len_c;
            dat_sr    <= cmd_data;
            cap       <= '0;
            idx       <= '0;
            cnt       <= '0;
            tdi       <= 1'b0;
            case (cmd_op)
              OP_RESET: begin
`ifdef JTAG_DRV_TRST_EN
                state <= ST_TRST;
                trst  <= 1'b0;
                tms   <= 1'b1;
                rem   <= RW'(1);
`else
                state  <= ST_TMS_SEQ;
                tms    <= 1'b1;
                tms_sr <= 5'b01111;
                rem    <= RW'(5);
`endif
              end
              OP_IR: begin
                state  <= ST_TMS_SEQ;
                tms    <= 1'b1;
                tms_sr <= 5'b00001;
                rem    <= RW'(3);
              end
              OP_DR: begin
                state  <= ST_TMS_SEQ;
                tms    <= 1'b1;
                tms_sr <= 5'b00000;
                rem    <= RW'(2);
              end
              default: begin
                state  <= ST_TMS_SEQ;
                tms    <= 1'b0;
                tms_sr <= 5'b00000;
                rem    <= RW'(cmd_len);
              end
            endcase
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          if (cnt == HI_START) begin
            if (state != ST_TRST) tck <= 1'b1;
            if (state == ST_SHIFT) cap[idx] <= tdo;
          end
          if (cnt == STEP_END) begin
            cnt <= '0;
            tck <= 1'b0;
            if (rem != '0) begin
              rem <= rem - 1'b1;
              case (state)
                ST_TMS_SEQ: begin
                  tms    <= tms_sr[0];
                  tms_sr <= tms_sr >> 1;
                end
                ST_SHIFT: begin
                  tdi    <= dat_sr[0];
                  dat_sr <= dat_sr >> 1;
                  tms    <= (rem == RW'(1));
                  idx    <= idx + 1'b1;
                end
                ST_EXIT: tms <= 1'b0;
                default: tms <= 1'b1;
              endcase
            end else begin
              case (state)
                ST_TRST: begin
                  state  <= ST_TMS_SEQ;
                  trst   <= 1'b1;
                  tms    <= 1'b1;
                  tms_sr <= 5'b01111;
                  rem    <= RW'(5);
                end
                ST_TMS_SEQ: begin
                  if (op == OP_IR || op == OP_DR) begin
                    state  <= ST_SHIFT;
                    tdi    <= dat_sr[0];
                    dat_sr <= dat_sr >> 1;
                    tms    <= (len == '0);
                    rem    <= RW'(len);
                  end else begin
                    state     <= ST_DONE;
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                  end
                end
                ST_SHIFT: begin
                  state <= ST_EXIT;
                  tms   <= 1'b1;
                  tdi   <= 1'b0;
                  rem   <= RW'(1);
                end
                default: begin
                  state     <= ST_DONE;
                  rsp_valid <= 1'b1;
                  rsp_data  <= cap;
                end
              endcase
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_driver.sv
// Directed bench for jtag_driver: logs tms/tdi on each tck rise and checks sequences, timing and responses.
module tb_jtag_driver;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 5;
  localparam int TD     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'd0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              tck, tms, tdi, tdo, trst;

  always #5 clk = ~clk;

  jtag_driver #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TCK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .trst(trst)
  );

  int total = 0;
  int bad = 0;
  int ntck = 0;
  int base = 0;
  int trst_lo = 0;
  int rsp_cnt = 0;
  bit tms_log[$];
  bit tdi_log[$];
  bit loop = 1'b1;
  logic [63:0] pat = '0;
  logic [31:0] last_rsp;
  int last_cyc;

  always @(posedge tck) begin
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
    ntck++;
  end

  always @(negedge clk) begin
    if (!trst) trst_lo++;
    if (rsp_valid) rsp_cnt++;
  end

  // tdo either loops tdi back or plays a per-step pattern indexed from command start
  assign tdo = loop ? tdi : pat[6'(ntck - base)];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] log_vec(input bit sel_tdi, input int from, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n && i < 64; i++) v[i] = sel_tdi ? tdi_log[from + i] : tms_log[from + i];
    return v;
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data);
    int n;
    @(negedge clk);
    base = ntck;
    cmd_op = op;
    cmd_len = len;
    cmd_data = data;
    cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        cmd_valid = 1'b0;
        check("busy_ready", cmd_ready, 0);
      end
    end while (!rsp_valid && n < 5000);
    check("rsp_seen", rsp_valid, 1);
    last_rsp = rsp_data;
    last_cyc = n - 1;
    @(negedge clk);
    check("ready_back", cmd_ready, 1);
    check("rsp_pulse", rsp_valid, 0);
  endtask

  task automatic check_reset_cmd();
    int t0;
    t0 = trst_lo;
    run_cmd(2'd0, 5'd0, 32'h0);
    check("rst_tms", log_vec(0, base, 6), 64'h1F);
    check("rst_steps", 64'(ntck - base), 64'd6);
    check("rst_rsp", 64'(last_rsp), 64'h0);
`ifdef JTAG_DRV_TRST_EN
    check("trst_low", 64'(trst_lo - t0), 64'(4 * TD));
    check("rst_cyc", 64'(last_cyc), 64'(16 * TD));
`else
    check("trst_high", 64'(trst_lo - t0), 64'd0);
    check("rst_cyc", 64'(last_cyc), 64'(12 * TD));
`endif
  endtask

  initial begin
    int n, n1, n2, r0;
    logic [31:0] r2;

    repeat (3) @(negedge clk);
    check("rv_tck", tck, 0);
    check("rv_tms", tms, 1);
    check("rv_tdi", tdi, 0);
    check("rv_trst", trst, 1);
    check("rv_rspv", rsp_valid, 0);
    check("rv_rspd", 64'(rsp_data), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rv_ready", cmd_ready, 1);

    check_reset_cmd();

    loop = 1'b1;
    run_cmd(2'd2, 5'd7, 32'hA5);
    check("dr8_tms", log_vec(0, base, 13), 64'hC01);
    check("dr8_tdi", log_vec(1, base, 13), 64'h528);
    check("dr8_steps", 64'(ntck - base), 64'd13);
    check("dr8_rsp", 64'(last_rsp), 64'hA5);
    check("dr8_cyc", 64'(last_cyc), 64'(26 * TD));

    run_cmd(2'd2, 5'd31, 32'hDEADBEEF);
    check("dr32_rsp", 64'(last_rsp), 64'hDEADBEEF);
    check("dr32_steps", 64'(ntck - base), 64'd37);
    check("dr32_cyc", 64'(last_cyc), 64'(74 * TD));

    loop = 1'b0;
    pat = 64'h10;
    run_cmd(2'd1, 5'd3, 32'h3);
    check("ir4_tms", log_vec(0, base, 10), 64'h183);
    check("ir4_tdi", log_vec(1, base, 10), 64'h30);
    check("ir4_rsp", 64'(last_rsp), 64'h1);
    check("ir4_cyc", 64'(last_cyc), 64'(20 * TD));

    pat = (64'hABC << 3) | (64'hF << 15) | 64'h7;
    run_cmd(2'd2, 5'd11, 32'h5A3);
    check("dr12_tms", log_vec(0, base, 17), 64'hC001);
    check("dr12_tdi", log_vec(1, base, 17), 64'h5A3 << 3);
    check("dr12_rsp", 64'(last_rsp), 64'hABC);

    pat = '1;
    run_cmd(2'd3, 5'd9, 32'hFFFF_FFFF);
    check("idle_tms", log_vec(0, base, 10), 64'h0);
    check("idle_tdi", log_vec(1, base, 10), 64'h0);
    check("idle_steps", 64'(ntck - base), 64'd10);
    check("idle_cyc", 64'(last_cyc), 64'(20 * TD));
    check("idle_rsp", 64'(last_rsp), 64'h0);

    // abort a 32-bit DR scan mid-flight
    loop = 1'b1;
    @(negedge clk);
    base = ntck;
    cmd_op = 2'd2;
    cmd_len = 5'd31;
    cmd_data = 32'hFFFF_FFFF;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (60) @(negedge clk);
    r0 = rsp_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ab_tck", tck, 0);
    check("ab_tms", tms, 1);
    check("ab_trst", trst, 1);
    check("ab_ready", cmd_ready, 1);
    check("ab_rspv", rsp_valid, 0);
    repeat (200) @(negedge clk);
    check("ab_no_rsp", 64'(rsp_cnt - r0), 64'd0);
    check_reset_cmd();

    // back-to-back with cmd_valid held: IDLE x2 then DR of 4 bits
    @(negedge clk);
    base = ntck;
    cmd_op = 2'd3;
    cmd_len = 5'd1;
    cmd_data = 32'h0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_op = 2'd2;
    cmd_len = 5'd3;
    cmd_data = 32'h9;
    n = 1;
    n1 = 0;
    n2 = 0;
    r2 = '0;
    while (n < 5000 && n2 == 0) begin
      if (rsp_valid && n1 == 0) n1 = n;
      else if (rsp_valid) begin
        n2 = n;
        r2 = rsp_data;
      end
      if (n1 != 0 && n == n1 + 1) check("b2b_ready", cmd_ready, 1);
      if (n1 != 0 && n == n1 + 2) begin
        check("b2b_taken", cmd_ready, 0);
        cmd_valid = 1'b0;
      end
      if (n2 == 0) begin
        @(negedge clk);
        n++;
      end
    end
    cmd_valid = 1'b0;
    check("b2b_first", 64'(n1 - 1), 64'(4 * TD));
    check("b2b_gap", 64'(n2 - n1), 64'(18 * TD + 2));
    check("b2b_edges", 64'(ntck - base), 64'd11);
    check("b2b_tms", log_vec(0, base + 2, 9), 64'hC1);
    check("b2b_rsp", 64'(r2), 64'h9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_driver.md
# jtag_driver

Host-side JTAG master that drives the scan test access port: it generates `tck`, `tms`, `tdi` and `trst` toward the TAP, and samples `tdo` back. A parallel command interface issues TAP reset, IR scans, DR scans and idle cycles. The TAP state is walked with fixed TMS sequences, and captured TDO bits are returned as a parallel response. It runs the SPM scan chain from an on-chip or bench-side test controller.

## Interface
- `DATA_W`, 32: maximum scan length in bits; width of `cmd_data`/`rsp_data`.
- `LEN_W`, 5: width of `cmd_len`; must satisfy 2^LEN_W >= DATA_W.
- `TCK_DIV`, 2: `clk` cycles per `tck` half-period; >= 1.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  driver idle and able to accept a command.
- `cmd_op`  in  2  0=RESET, 1=IR scan, 2=DR scan, 3=IDLE.
- `cmd_len`  in  LEN_W  bit count minus one (scan of N bits: `cmd_len`=N-1); idle cycles minus one.
- `cmd_data`  in  DATA_W  TDI data, bit 0 shifted first.
- `rsp_valid`  out  1  one-cycle pulse on command completion.
- `rsp_data`  out  DATA_W  captured TDO bits; bit i = i-th bit captured; bits >= N are 0.
- `tck`  out  1  test clock.
- `tms`  out  1  test mode select.
- `tdi`  out  1  test data to TAP.
- `tdo`  in  1  test data from TAP (the wrapper's `tdo_pad_o`).
- `trst`  out  1  TAP reset, active-low (matches the wrapper's `trst`).

## Operation
- FSM states: IDLE, TRST, TMS_SEQ, SHIFT, EXIT, DONE.
- Accept on `cmd_valid && cmd_ready`. Latch op, len and data. `cmd_ready`=1 only in IDLE.
- Each TAP step is one `tck` period, low half then high half.
- `tms`/`tdi` update when `tck` falls, i.e. at the start of the low half.
- `tdo` is sampled on the `clk` edge that drives `tck` high.
- The driver assumes the TAP is in Run-Test/Idle (RTI) at the start of every non-RESET command, and always leaves it in RTI.
- RESET: TRST phase (see Configuration), then 5 steps with TMS=1 (Test-Logic-Reset), then 1 step with TMS=0 (RTI).
- IR scan preamble: TMS 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
- DR scan preamble: TMS 1,0,0 (Select-DR, Capture-DR, Shift-DR).
- SHIFT: N steps, `tdi`=data[i]. TMS=0 except on the final bit, where TMS=1 (Exit1).
- EXIT: TMS 1 (Update), then 0 (RTI).
- IDLE: `cmd_len`+1 steps with TMS=0, `tdi`=0.
- DONE: one cycle with `rsp_valid`=1, then back to IDLE. RESET/IDLE return `rsp_data`=0.
- `rsp_data` holds its value until the next `rsp_valid`.
- `cmd_len` >= DATA_W on a scan: clamped to DATA_W-1.
- Non-RESET commands issued after `rst` but before any RESET are executed as-is. The bench must start with RESET.

## Timing
- Reset values: `tck`=0, `tms`=1, `tdi`=0, `trst`=1, `cmd_ready`=1 (first cycle after `rst` drops), `rsp_valid`=0, `rsp_data`=0.
- `rst` mid-command: abort immediately to reset values. No `rsp_valid` is issued for the aborted command.
- Step length: 2*TCK_DIV `clk` cycles. `tck` is low when idle; no stray edges occur between commands.
- Command duration in steps: IR = N+6, DR = N+5, IDLE = `cmd_len`+1, RESET = 8 (6 without TRST).
- `rsp_valid` asserts on the first `clk` cycle after the final step's high half ends. `cmd_ready` returns to 1 on the following cycle.
- Latency from accept to first `tck` low half: 1 `clk` cycle.

## Configuration
- `JTAG_DRV_TRST_EN` defined: RESET drives `trst`=0 for 2 steps with `tck` held low and `tms`=1, then runs the TMS sequence.
- `JTAG_DRV_TRST_EN` undefined: `trst` is tied to 1; RESET is the 6-step TMS-only sequence.

## Test plan
- `rst` then RESET (macro on) -> `trst` low for exactly 4*TCK_DIV cycles; then TMS 1,1,1,1,1,0; `rsp_valid` pulse with `rsp_data`=0.
- DR scan, N=8, `cmd_data`=0xA5, with the wrapper in loopback (`sout` tied to `sin`) -> TMS 1,0,0, then 7×0, 1, then 1,0; `tdi` sequence 1,0,1,0,0,1,0,1; 13 steps total.
- IR scan, N=4, `cmd_data`=0x3, against the `tap_wrapper` model -> TMS 1,1,0,0,0,0,0,1,1,0; `rsp_data` = IR capture value 0x1 (bits 4..31 = 0).
- IDLE, `cmd_len`=9 -> exactly 10 `tck` rising edges with `tms`=0; `rsp_valid` after 20*TCK_DIV cycles; `tdo` ignored.
- `rst` pulse in the middle of a 32-bit DR scan -> next cycle shows `tck`=0, `tms`=1, `trst`=1, `cmd_ready`=1, and no `rsp_valid`. A following RESET completes normally.
- Back-to-back commands with `cmd_valid` held high -> second command accepted on the cycle `cmd_ready` returns, no idle `tck` edges between them; TCK_DIV=1 and TCK_DIV=3 both pass.
